div_clk_checker: RTL

//  Self-test monitor for the ripple clock dividers: consumes a divided clock (e.g. the /8 output),

---
 rtl/div_chk_pkg.sv | 21 ++
 rtl/sync_edge_det.sv | 37 +++
 rtl/div_clk_checker.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/div_chk_pkg.sv
// Shared definitions for the divided-clock self-test monitors.
// Provides the checker FSM encoding, error counter width and timeout helper.
package div_chk_pkg;

  localparam int ERR_CNT_W    = 8;
  localparam int TIMEOUT_MULT = 2;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_EDGE = 3'd1,
    ST_ACQUIRE   = 3'd2,
    ST_LOCKED    = 3'd3,
    ST_FAULT     = 3'd4
  } state_t;

  // A stuck input is declared after this many source cycles without a rise.
  function automatic int timeout_cycles(input int div_ratio);
    return TIMEOUT_MULT * div_ratio;
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// 2-FF synchronizer plus history flop; rise/fall are one-cycle pulses.
// Latency: edge pulse is usable at the 3rd clk edge after d_in changes; no backpressure.
module sync_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic d_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s1_q, s2_q, s3_q;
  logic s1_d, s2_d, s3_d;

  always_comb begin
    s1_d = d_in;
    s2_d = s1_q;
    s3_d = s2_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

  assign level = s2_q;
  assign rise  = s2_q & ~s3_q;
  assign fall  = ~s2_q & s3_q;

endmodule

// File: rtl/div_clk_checker.sv
// Measures period/high time of a divided clock in source cycles and checks them for lock/faults.
// Latency: outputs registered one cycle after the synchronized edge; no backpressure (pure monitor).
module div_clk_checker
  import div_chk_pkg::*;
#(
  parameter int DIV_RATIO    = 8,
  parameter int LOCK_PERIODS = 4,
  parameter int CNT_W        = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 clear_err,
  input  logic                 clk_div_in,
  output logic                 locked,
  output logic                 err,
  output logic                 err_sticky,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0]     period_cnt,
  output logic [CNT_W-1:0]     high_cnt
);

  localparam int                 GOOD_W    = $clog2(LOCK_PERIODS + 1);
  localparam logic [CNT_W-1:0]   CNT_MAX   = '1;
  localparam logic [CNT_W-1:0]   PER_EXP   = CNT_W'(DIV_RATIO);
  localparam logic [CNT_W-1:0]   HIGH_EXP  = CNT_W'(DIV_RATIO / 2);
  localparam logic [CNT_W-1:0]   TMO_LAST  = CNT_W'(timeout_cycles(DIV_RATIO) - 1);
  localparam logic [GOOD_W-1:0]  GOOD_LOCK = GOOD_W'(LOCK_PERIODS);
  localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

  logic div_level, div_rise, div_fall;

  sync_edge_det u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_in  (clk_div_in),
    .level (div_level),
    .rise  (div_rise),
    .fall  (div_fall)
  );

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d, hcnt_q, hcnt_d;
  logic [CNT_W-1:0]       period_q, period_d, high_q, high_d;
  logic [GOOD_W-1:0]      good_q, good_d;
  logic                   locked_q, locked_d, err_q, err_d, sticky_q, sticky_d;
  logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;

  logic [CNT_W-1:0] cnt_plus, hcnt_plus;
  logic             running, timeout, good_period;

  always_comb begin
    cnt_plus    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    hcnt_plus   = (hcnt_q == CNT_MAX) ? hcnt_q : hcnt_q + CNT_W'(1);
    running     = (state_q == ST_WAIT_EDGE) || (state_q == ST_ACQUIRE) || (state_q == ST_LOCKED);
    // A rise in the same cycle always takes precedence over the timeout.
    timeout     = running && !div_rise && (cnt_q == TMO_LAST);
    good_period = (cnt_plus == PER_EXP) && (high_q == HIGH_EXP);
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hcnt_d    = hcnt_q;
    good_d    = good_q;
    period_d  = period_q;
    high_d    = high_q;
    locked_d  = locked_q;
    err_d     = 1'b0;
    sticky_d  = sticky_q;
    err_cnt_d = err_cnt_q;

    if (clear_err) begin
      sticky_d  = 1'b0;
      err_cnt_d = '0;
    end

    if (!en) begin
      state_d  = ST_IDLE;
      locked_d = 1'b0;
      cnt_d    = '0;
      hcnt_d   = '0;
      good_d   = '0;
    end else if (state_q == ST_IDLE) begin
      state_d = ST_WAIT_EDGE;
      cnt_d   = '0;
      hcnt_d  = '0;
      good_d  = '0;
    end else begin
      cnt_d = (div_rise || timeout) ? '0 : cnt_plus;
      // High time only accumulates while the synchronized input is high.
      if (div_rise)       hcnt_d = '0;
      else if (div_level) hcnt_d = hcnt_plus;
      if (div_rise) period_d = cnt_plus;
      if (div_fall) high_d   = hcnt_plus;

      case (state_q)
        ST_WAIT_EDGE: begin
          if (div_rise) begin
            state_d = ST_ACQUIRE;
            good_d  = '0;
          end else if (timeout) begin
            state_d = ST_FAULT;
          end
        end
        ST_ACQUIRE: begin
          if (div_rise) begin
            if (!good_period) begin
              good_d = '0;
            end else if (good_q + GOOD_W'(1) == GOOD_LOCK) begin
              state_d  = ST_LOCKED;
              locked_d = 1'b1;
              good_d   = '0;
            end else begin
              good_d = good_q + GOOD_W'(1);
            end
          end else if (timeout) begin
            state_d = ST_FAULT;
          end
        end
        ST_LOCKED: begin
          if ((div_rise && !good_period) || timeout) state_d = ST_FAULT;
        end
        ST_FAULT: begin
          err_d     = 1'b1;
          sticky_d  = 1'b1;
          err_cnt_d = clear_err ? ERR_CNT_W'(1)
                    : (err_cnt_q == ERR_MAX) ? err_cnt_q : err_cnt_q + ERR_CNT_W'(1);
          locked_d  = 1'b0;
          good_d    = '0;
          state_d   = ST_WAIT_EDGE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      hcnt_q    <= '0;
      good_q    <= '0;
      period_q  <= '0;
      high_q    <= '0;
      locked_q  <= 1'b0;
      err_q     <= 1'b0;
      sticky_q  <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hcnt_q    <= hcnt_d;
      good_q    <= good_d;
      period_q  <= period_d;
      high_q    <= high_d;
      locked_q  <= locked_d;
      err_q     <= err_d;
      sticky_q  <= sticky_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign locked     = locked_q;
  assign err        = err_q;
  assign err_sticky = sticky_q;
  assign err_cnt    = err_cnt_q;
  assign period_cnt = period_q;
  assign high_cnt   = high_q;

endmodule
